// File: rtl/regfile_mp_bypass.sv
// Two-write, two-read register file with same-cycle write-to-read bypass,
// a per-register busy scoreboard and a post-reset clear sweep of a resetless array.
module regfile_mp_bypass #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   READ_REG1,
  input  logic [AW-1:0]   READ_REG2,
  output logic [XLEN-1:0] READ_DATA1,
  output logic [XLEN-1:0] READ_DATA2,
  output logic            READ_BUSY1,
  output logic            READ_BUSY2,
  input  logic            WE0,
  input  logic [AW-1:0]   WADDR0,
  input  logic [XLEN-1:0] WDATA0,
  input  logic            WE1,
  input  logic [AW-1:0]   WADDR1,
  input  logic [XLEN-1:0] WDATA1,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_REG,
  output logic            READY,
  output logic            CONFLICT
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t            state_r;
  logic [AW:0]       cnt_r;
  logic [NREGS-1:0]  busy_r;
  logic [NREGS-1:0]  busy_nxt_s;
  logic              conflict_r;
  logic [XLEN-1:0]   mem_r [NREGS];
  logic              run_s;
  logic              same_addr_s;
  logic              w0_commit_s;

  assign run_s       = (state_r == ST_RUN);
  assign same_addr_s = WE0 && WE1 && (WADDR0 == WADDR1) && (WADDR0 != {AW{1'b0}});
  // W1 owns an address it shares with W0 in the same cycle.
  assign w0_commit_s = WE0 && (WADDR0 != {AW{1'b0}}) && !(WE1 && (WADDR1 == WADDR0));

  function automatic logic [XLEN-1:0] read_mux(
    input logic            run,
    input logic [AW-1:0]   addr,
    input logic            we0,
    input logic [AW-1:0]   waddr0,
    input logic [XLEN-1:0] wdata0,
    input logic            we1,
    input logic [AW-1:0]   waddr1,
    input logic [XLEN-1:0] wdata1,
    input logic [XLEN-1:0] entry
  );
    logic [XLEN-1:0] val;
    if (!run || (addr == {AW{1'b0}})) begin
      val = {XLEN{1'b0}};
    end else if (we1 && (waddr1 == addr)) begin
      val = wdata1;
    end else if (we0 && (waddr0 == addr)) begin
      val = wdata0;
    end else begin
      val = entry;
    end
    return val;
  endfunction

  // Sweep/run sequencing and the sticky same-address write conflict flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_INIT;
      cnt_r      <= {(AW+1){1'b0}};
      conflict_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          // cnt_r reaching NREGS means the last entry was cleared on the previous edge.
          if (cnt_r[AW]) begin
            state_r <= ST_RUN;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          if (same_addr_s) begin
            conflict_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= {(AW+1){1'b0}};
        end
      endcase
    end
  end

  // Next busy vector: issue set wins over a same-edge W1 clear; r0 never busy.
  always_comb begin
    busy_nxt_s = busy_r;
    if (run_s) begin
      if (WE1) begin
        busy_nxt_s[WADDR1] = 1'b0;
      end else begin
        busy_nxt_s = busy_r;
      end
      if (ISSUE_EN) begin
        busy_nxt_s[ISSUE_REG] = 1'b1;
      end else begin
        busy_nxt_s[0] = 1'b0;
      end
    end else begin
      busy_nxt_s = busy_r;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Storage array: no reset term, cleared by the sweep instead.
  always_ff @(posedge CLK) begin
    if (!run_s) begin
      if (!cnt_r[AW]) begin
        mem_r[cnt_r[AW-1:0]] <= {XLEN{1'b0}};
      end
    end else begin
      if (WE1 && (WADDR1 != {AW{1'b0}})) begin
        mem_r[WADDR1] <= WDATA1;
      end
      if (w0_commit_s) begin
        mem_r[WADDR0] <= WDATA0;
      end
    end
  end

  // Combinational read ports with bypass and busy reporting.
  always_comb begin
    READ_DATA1 = read_mux(run_s, READ_REG1, WE0, WADDR0, WDATA0, WE1, WADDR1, WDATA1,
                          mem_r[READ_REG1]);
    READ_DATA2 = read_mux(run_s, READ_REG2, WE0, WADDR0, WDATA0, WE1, WADDR1, WDATA1,
                          mem_r[READ_REG2]);
    READ_BUSY1 = run_s && (READ_REG1 != {AW{1'b0}}) && busy_r[READ_REG1]
                 && !(WE1 && (WADDR1 == READ_REG1));
    READ_BUSY2 = run_s && (READ_REG2 != {AW{1'b0}}) && busy_r[READ_REG2]
                 && !(WE1 && (WADDR1 == READ_REG2));
  end

  assign READY    = run_s;
  assign CONFLICT = conflict_r;

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed bench for regfile_mp_bypass; expectations are queued as stimulus is
// driven and compared once the outputs have settled.
module tb_regfile_mp_bypass;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam int O_RD1  = 0;
  localparam int O_RD2  = 1;
  localparam int O_RB1  = 2;
  localparam int O_RB2  = 3;
  localparam int O_RDY  = 4;
  localparam int O_CONF = 5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [AW-1:0]   READ_REG1, READ_REG2;
  logic [XLEN-1:0] READ_DATA1, READ_DATA2;
  logic            READ_BUSY1, READ_BUSY2;
  logic            WE0, WE1, ISSUE_EN;
  logic [AW-1:0]   WADDR0, WADDR1, ISSUE_REG;
  logic [XLEN-1:0] WDATA0, WDATA1;
  logic            READY, CONFLICT;

  regfile_mp_bypass #(.XLEN(XLEN), .NREGS(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .READ_REG1(READ_REG1), .READ_REG2(READ_REG2),
    .READ_DATA1(READ_DATA1), .READ_DATA2(READ_DATA2),
    .READ_BUSY1(READ_BUSY1), .READ_BUSY2(READ_BUSY2),
    .WE0(WE0), .WADDR0(WADDR0), .WDATA0(WDATA0),
    .WE1(WE1), .WADDR1(WADDR1), .WDATA1(WDATA1),
    .ISSUE_EN(ISSUE_EN), .ISSUE_REG(ISSUE_REG),
    .READY(READY), .CONFLICT(CONFLICT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_RD1:   return READ_DATA1;
      O_RD2:   return READ_DATA2;
      O_RB1:   return {31'd0, READ_BUSY1};
      O_RB2:   return {31'd0, READ_BUSY2};
      O_RDY:   return {31'd0, READY};
      O_CONF:  return {31'd0, CONFLICT};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WE0 = 1'b0; WE1 = 1'b0; ISSUE_EN = 1'b0;
    WADDR0 = '0; WADDR1 = '0; ISSUE_REG = '0;
    WDATA0 = '0; WDATA1 = '0;
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 0; k <= 32; k++) begin
      tick();
      expect_out(tag, O_RDY, (k == 32) ? 32'd1 : 32'd0);
      drain();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    READ_REG1 = 5'd5;
    READ_REG2 = 5'd3;
    repeat (2) @(posedge CLK);
    #1;
    expect_out("rst_ready", O_RDY, 32'd0);
    expect_out("rst_conflict", O_CONF, 32'd0);
    expect_out("rst_rd1", O_RD1, 32'd0);
    drain();

    // Writes and issues during the sweep must be ignored.
    WE0 = 1'b1; WADDR0 = 5'd5; WDATA0 = 32'hFFFF_FFFF;
    ISSUE_EN = 1'b1; ISSUE_REG = 5'd3;
    RST_N = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      tick();
      if (k == 4) idle_inputs();
      expect_out("sweep_ready", O_RDY, (k == 32) ? 32'd1 : 32'd0);
      if (k == 2) begin
        expect_out("init_rd1_bypass_ignored", O_RD1, 32'd0);
        expect_out("init_rb2", O_RB2, 32'd0);
      end
      drain();
    end

    for (int r = 1; r < 32; r++) begin
      READ_REG1 = AW'(r);
      READ_REG2 = AW'(r);
      expect_out("cleared_rd1", O_RD1, 32'd0);
      expect_out("cleared_rb2", O_RB2, 32'd0);
      drain();
    end

    tick();
    WE0 = 1'b1; WADDR0 = 5'd5; WDATA0 = 32'hDEAD_BEEF; READ_REG1 = 5'd5;
    expect_out("w0_bypass", O_RD1, 32'hDEAD_BEEF);
    drain();
    tick();
    idle_inputs();
    expect_out("w0_retained", O_RD1, 32'hDEAD_BEEF);
    drain();

    tick();
    WE0 = 1'b1; WADDR0 = 5'd0; WDATA0 = 32'h0000_1234; READ_REG1 = 5'd0;
    expect_out("r0_bypass", O_RD1, 32'd0);
    drain();
    tick();
    idle_inputs();
    expect_out("r0_after", O_RD1, 32'd0);
    drain();

    tick();
    WE0 = 1'b1; WADDR0 = 5'd7; WDATA0 = 32'h11;
    WE1 = 1'b1; WADDR1 = 5'd7; WDATA1 = 32'h22;
    READ_REG2 = 5'd7;
    expect_out("conflict_bypass", O_RD2, 32'h22);
    expect_out("conflict_not_yet", O_CONF, 32'd0);
    drain();
    tick();
    idle_inputs();
    expect_out("conflict_commit", O_RD2, 32'h22);
    expect_out("conflict_set", O_CONF, 32'd1);
    drain();

    // Independent dual writes do not raise CONFLICT further or interfere.
    tick();
    WE0 = 1'b1; WADDR0 = 5'd3; WDATA0 = 32'h33;
    WE1 = 1'b1; WADDR1 = 5'd4; WDATA1 = 32'h44;
    READ_REG1 = 5'd3; READ_REG2 = 5'd4;
    expect_out("dual_rd1", O_RD1, 32'h33);
    expect_out("dual_rd2", O_RD2, 32'h44);
    drain();
    tick();
    idle_inputs();
    expect_out("dual_rd1_commit", O_RD1, 32'h33);
    expect_out("dual_rd2_commit", O_RD2, 32'h44);
    expect_out("conflict_sticky", O_CONF, 32'd1);
    drain();

    tick();
    ISSUE_EN = 1'b1; ISSUE_REG = 5'd9; READ_REG1 = 5'd9;
    expect_out("issue_same_cycle", O_RB1, 32'd0);
    drain();
    tick();
    idle_inputs();
    expect_out("issue_busy", O_RB1, 32'd1);
    drain();
    tick();
    WE0 = 1'b1; WADDR0 = 5'd9; WDATA0 = 32'h55;
    expect_out("w0_busy_hold", O_RB1, 32'd1);
    expect_out("w0_busy_bypass", O_RD1, 32'h55);
    drain();
    tick();
    idle_inputs();
    expect_out("w0_no_clear", O_RB1, 32'd1);
    expect_out("w0_busy_data", O_RD1, 32'h55);
    drain();
    tick();
    WE1 = 1'b1; WADDR1 = 5'd9; WDATA1 = 32'hAA;
    expect_out("w1_unblock", O_RB1, 32'd0);
    expect_out("w1_bypass", O_RD1, 32'hAA);
    drain();
    tick();
    idle_inputs();
    expect_out("w1_cleared", O_RB1, 32'd0);
    expect_out("w1_data", O_RD1, 32'hAA);
    drain();
    tick();
    ISSUE_EN = 1'b1; ISSUE_REG = 5'd9;
    WE1 = 1'b1; WADDR1 = 5'd9; WDATA1 = 32'hBB;
    expect_out("issue_w1_same_rb", O_RB1, 32'd0);
    expect_out("issue_w1_same_rd", O_RD1, 32'hBB);
    drain();
    tick();
    idle_inputs();
    expect_out("issue_wins", O_RB1, 32'd1);
    expect_out("issue_w1_data", O_RD1, 32'hBB);
    drain();

    tick();
    ISSUE_EN = 1'b1; ISSUE_REG = 5'd0; READ_REG2 = 5'd0;
    drain();
    tick();
    idle_inputs();
    expect_out("issue_r0", O_RB2, 32'd0);
    drain();

    tick();
    RST_N = 1'b0;
    expect_out("async_ready", O_RDY, 32'd0);
    expect_out("async_busy", O_RB1, 32'd0);
    expect_out("async_conflict", O_CONF, 32'd0);
    drain();
    tick();
    RST_N = 1'b1;
    repeat (10) tick();
    RST_N = 1'b0;
    expect_out("midsweep_ready", O_RDY, 32'd0);
    drain();
    tick();
    RST_N = 1'b1;
    sweep_check("resweep_ready");

    READ_REG1 = 5'd9; READ_REG2 = 5'd7;
    expect_out("resweep_busy", O_RB1, 32'd0);
    expect_out("resweep_rd1", O_RD1, 32'd0);
    expect_out("resweep_rd2", O_RD2, 32'd0);
    expect_out("resweep_conflict", O_CONF, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
- Parametrised successor to the core's 32x32 register file, for the RV32IM pipeline with a multi-cycle M-unit/load writeback path.
- Two write ports: W0 for the ALU writeback and W1 for the long-latency writeback.
- Two combinational read ports with same-cycle write-to-read bypass.
- Per-register busy scoreboard, and a sequential post-reset clear sweep so the storage array needs no reset and can map to LUT-RAM.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived, not overridable).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- READ_REG1  in  AW  read port 1 address.
- READ_REG2  in  AW  read port 2 address.
- READ_DATA1  out  XLEN  read port 1 data.
- READ_DATA2  out  XLEN  read port 2 data.
- READ_BUSY1  out  1  read port 1 register has a pending W1 writeback.
- READ_BUSY2  out  1  read port 2 register has a pending W1 writeback.
- WE0  in  1  write enable, port 0 (ALU).
- WADDR0  in  AW  write address, port 0.
- WDATA0  in  XLEN  write data, port 0.
- WE1  in  1  write enable, port 1 (long-latency).
- WADDR1  in  AW  write address, port 1.
- WDATA1  in  XLEN  write data, port 1.
- ISSUE_EN  in  1  mark ISSUE_REG busy (long-latency op issued).
- ISSUE_REG  in  AW  destination register of the issued op.
- READY  out  1  high once the clear sweep is complete.
- CONFLICT  out  1  sticky flag: WE0 and WE1 asserted to the same non-zero address in one cycle.

Behaviour:
- States:
  - INIT: entered asynchronously while RST_N=0. On reset, clear counter=0, all busy bits=0, CONFLICT=0, READY=0.
  - INIT sweep: after RST_N rises, write 0 to entry[counter] each cycle and increment the counter. After entry NREGS-1 is written, go to RUN next edge. READY rises exactly NREGS cycles after the first rising edge with RST_N=1.
  - RUN: normal operation; READY=1.
- Array storage has no reset term; only the FSM, counter, busy bits and CONFLICT are asynchronously reset.
- Reset asserted mid-sweep or in RUN: immediate return to INIT with counter=0; the sweep restarts in full.
- In INIT: READ_DATAx=0, READ_BUSYx=0; WE0, WE1 and ISSUE_EN are ignored.
- Register 0: always reads 0, is never busy, and ignores writes and issues.
- Reads (RUN) are combinational, in this priority order:
  1. Address 0 returns 0.
  2. WE1 with WADDR1==addr returns WDATA1.
  3. WE0 with WADDR0==addr returns WDATA0.
  4. Otherwise the array entry.
- Writes commit on the rising edge. When WE0 and WE1 target the same non-zero address, W1 wins and CONFLICT sets. CONFLICT clears only on reset.
- Scoreboard:
  - ISSUE_EN sets busy[ISSUE_REG].
  - WE1 clears busy[WADDR1].
  - WE0 never changes busy.
  - Same-edge ISSUE_EN and WE1 on the same register: set wins, because a new op has been issued.
- READ_BUSYx = busy[addr] AND NOT (WE1 AND WADDR1==addr), so a same-cycle W1 bypass unblocks the reader. READ_BUSYx is 0 for address 0.
- No arithmetic; widths are exact. Addresses are always in range, since NREGS=2^AW.

Test Plan:
- Reset, then hold RST_N=1 -> READY=0 for 32 cycles and 1 on cycle 32; reads of r1..r31 return 0; with WE0=1 during INIT, a later read of r5 returns 0.
- RUN: write r5=0xDEADBEEF via W0 while READ_REG1=5 in the same cycle -> READ_DATA1=0xDEADBEEF combinationally; the value is retained next cycle with WE0=0. Write r0=0x1234 -> reads 0.
- Same cycle WE0 r7=0x11, WE1 r7=0x22 -> READ_DATA2 (addr 7)=0x22; next cycle r7=0x22 and CONFLICT=1, staying 1 until RST_N low.
- ISSUE_EN r9 -> READ_BUSY1(9)=1 next cycle. With WE1 r9=0xAA, READ_BUSY1=0 and READ_DATA1=0xAA in the same cycle; busy stays clear afterwards. ISSUE_EN r9 plus WE1 r9 on the same edge -> r9 busy=1.
- ISSUE_EN r0 -> READ_BUSY(0)=0. WE0 r9 while r9 is busy -> busy stays 1.
- Drop RST_N mid-sweep at counter=10 -> READY=0 and busy cleared immediately; after release READY rises 32 cycles later.
